// File: rtl/riscv_pkg.sv
// Shared definitions for the multicycle RISC-V control unit:
// FSM states, opcodes, aluop and alucontrol encodings.
package riscv_pkg;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    MEMADR,
    MEMREAD,
    MEMWB,
    MEMWRITE,
    EXECUTER,
    EXECUTEI,
    ALUWB,
    BEQ,
    JAL
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_SUB = 2'b01;
  localparam logic [1:0] ALUOP_FN  = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_SLL = 3'b110;
  localparam logic [2:0] ALU_SRL = 3'b111;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  typedef struct packed {
    logic       adrsrc;
    logic       memwrite;
    logic       irwrite;
    logic       regwrite;
    logic       branch;
    logic       pcupdate;
    logic [1:0] resultsrc;
    logic [1:0] alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
  } ctrl_t;

endpackage

// File: rtl/aludec.sv
// ALU operation decode from aluop, funct3 and the R-type subtract bit.
// Purely combinational.
module aludec
  import riscv_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [2:0] funct3,
  input  logic       op5,
  input  logic       funct7b5,
  output logic [2:0] alucontrol
);

  logic rsub;

  // only register-register ops may subtract; addi ignores bit 30
  assign rsub = op5 & funct7b5;

  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_ADD: alucontrol = ALU_ADD;
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FN: begin
        case (funct3)
          3'b000:  alucontrol = rsub ? ALU_SUB : ALU_ADD;
          3'b001:  alucontrol = ALU_SLL;
          3'b010:  alucontrol = ALU_SLT;
          3'b100:  alucontrol = ALU_XOR;
          3'b101:  alucontrol = ALU_SRL;
          3'b110:  alucontrol = ALU_OR;
          3'b111:  alucontrol = ALU_AND;
          default: alucontrol = ALU_ADD;
        endcase
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle RISC-V controller: Moore main FSM, immediate decode,
// branch-qualified PC enable and ALU decode.
module mc_controller
  import riscv_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic       pcwrite,
  output logic       adrsrc,
  output logic       memwrite,
  output logic       irwrite,
  output logic [1:0] resultsrc,
  output logic [1:0] alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] immsrc,
  output logic       regwrite,
  output logic [2:0] alucontrol
);

  state_t state;
  state_t next;
  ctrl_t  c;

  logic is_lw;
  logic is_sw;
  logic is_r;
  logic is_i;
  logic is_jal;
  logic is_beq;

  assign is_lw  = (op == OP_LW);
  assign is_sw  = (op == OP_SW);
  assign is_r   = (op == OP_R);
  assign is_i   = (op == OP_I);
  assign is_jal = (op == OP_JAL);
  assign is_beq = (op == OP_BEQ);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= FETCH;
    else          state <= next;
  end

  always_comb begin
    next = FETCH;
    case (state)
      FETCH: next = DECODE;
      DECODE: begin
        unique case (1'b1)
          is_lw, is_sw: next = MEMADR;
          is_r:         next = EXECUTER;
          is_i:         next = EXECUTEI;
          is_jal:       next = JAL;
          is_beq:       next = BEQ;
          default:      next = FETCH;
        endcase
      end
      MEMADR:   next = is_lw ? MEMREAD : MEMWRITE;
      MEMREAD:  next = MEMWB;
      EXECUTER: next = ALUWB;
      EXECUTEI: next = ALUWB;
      JAL:      next = ALUWB;
      default:  next = FETCH;
    endcase
  end

  always_comb begin
    c = '0;
    case (state)
      FETCH: begin
        c.irwrite   = 1'b1;
        c.alusrcb   = 2'b10;
        c.resultsrc = 2'b10;
        c.pcupdate  = 1'b1;
      end
      DECODE: begin
        c.alusrca = 2'b01;
        c.alusrcb = 2'b01;
      end
      MEMADR: begin
        c.alusrca = 2'b10;
        c.alusrcb = 2'b01;
      end
      MEMREAD: c.adrsrc = 1'b1;
      MEMWB: begin
        c.resultsrc = 2'b01;
        c.regwrite  = 1'b1;
      end
      MEMWRITE: begin
        c.adrsrc   = 1'b1;
        c.memwrite = 1'b1;
      end
      EXECUTER: begin
        c.alusrca = 2'b10;
        c.aluop   = ALUOP_FN;
      end
      EXECUTEI: begin
        c.alusrca = 2'b10;
        c.alusrcb = 2'b01;
        c.aluop   = ALUOP_FN;
      end
      ALUWB: c.regwrite = 1'b1;
      BEQ: begin
        c.alusrca = 2'b10;
        c.aluop   = ALUOP_SUB;
        c.branch  = 1'b1;
      end
      JAL: begin
        c.alusrca  = 2'b01;
        c.alusrcb  = 2'b10;
        c.pcupdate = 1'b1;
      end
      default: c = '0;
    endcase
  end

  always_comb begin
    unique case (1'b1)
      is_sw:   immsrc = IMM_S;
      is_beq:  immsrc = IMM_B;
      is_jal:  immsrc = IMM_J;
      default: immsrc = IMM_I;
    endcase
  end

  // reset_n gates the enables so nothing is written while held in reset
  assign pcwrite   = reset_n & (c.pcupdate | (c.branch & zero));
  assign irwrite   = reset_n & c.irwrite;
  assign regwrite  = reset_n & c.regwrite;
  assign memwrite  = reset_n & c.memwrite;
  assign adrsrc    = c.adrsrc;
  assign resultsrc = c.resultsrc;
  assign alusrca   = c.alusrca;
  assign alusrcb   = c.alusrcb;

  aludec u_aludec (
    .aluop      (c.aluop),
    .funct3     (funct3),
    .op5        (op[5]),
    .funct7b5   (funct7b5),
    .alucontrol (alucontrol)
  );

endmodule

// File: tb/tb_mc_controller.sv
// Bench for mc_controller: per-opcode state-sequence model plus
// directed literal checks and randomized instruction streams.
module tb_mc_controller;

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] JL  = 7'b1101111;
  localparam logic [6:0] BQ  = 7'b1100011;

  typedef enum {
    T_FETCH, T_DECODE, T_MEMADR, T_MEMREAD, T_MEMWB, T_MEMWRITE,
    T_EXECR, T_EXECI, T_ALUWB, T_BEQ, T_JAL
  } tstate_e;

  typedef struct {
    bit       adr, mw, ir, rw, br, pcu;
    bit [1:0] rs, a, b, aop;
  } row_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [6:0] op = LW;
  logic [2:0] funct3 = 3'b000;
  logic       funct7b5 = 1'b0;
  logic       zero = 1'b0;
  logic       pcwrite, adrsrc, memwrite, irwrite, regwrite;
  logic [1:0] resultsrc, alusrca, alusrcb, immsrc;
  logic [2:0] alucontrol;

  int checks = 0;
  int errors = 0;
  bit run = 0;
  tstate_e m_state = T_FETCH;
  tstate_e seq[$];
  row_t r;

  mc_controller dut (
    .clk(clk), .reset_n(reset_n), .op(op), .funct3(funct3),
    .funct7b5(funct7b5), .zero(zero), .pcwrite(pcwrite),
    .adrsrc(adrsrc), .memwrite(memwrite), .irwrite(irwrite),
    .resultsrc(resultsrc), .alusrca(alusrca), .alusrcb(alusrcb),
    .immsrc(immsrc), .regwrite(regwrite), .alucontrol(alucontrol)
  );

  always #5 clk = ~clk;

  function automatic row_t row(tstate_e s);
    row_t x = '{default: 0};
    case (s)
      T_FETCH:    begin x.ir = 1; x.b = 2; x.rs = 2; x.pcu = 1; end
      T_DECODE:   begin x.a = 1; x.b = 1; end
      T_MEMADR:   begin x.a = 2; x.b = 1; end
      T_MEMREAD:  x.adr = 1;
      T_MEMWB:    begin x.rs = 1; x.rw = 1; end
      T_MEMWRITE: begin x.adr = 1; x.mw = 1; end
      T_EXECR:    begin x.a = 2; x.aop = 2; end
      T_EXECI:    begin x.a = 2; x.b = 1; x.aop = 2; end
      T_ALUWB:    x.rw = 1;
      T_BEQ:      begin x.a = 2; x.aop = 1; x.br = 1; end
      T_JAL:      begin x.a = 1; x.b = 2; x.pcu = 1; end
      default:    ;
    endcase
    return x;
  endfunction

  function automatic logic [2:0] alu_exp(bit [1:0] aop, logic [2:0] f3,
                                         logic o5, logic f7);
    if (aop == 0) return 3'd0;
    if (aop == 1) return 3'd1;
    if (aop == 3) return 3'd0;
    case (f3)
      3'd0: return (o5 && f7) ? 3'd1 : 3'd0;
      3'd1: return 3'd6;
      3'd2: return 3'd5;
      3'd4: return 3'd4;
      3'd5: return 3'd7;
      3'd6: return 3'd3;
      3'd7: return 3'd2;
      default: return 3'd0;
    endcase
  endfunction

  function automatic logic [1:0] imm_exp(logic [6:0] o);
    if (o == SW) return 2'd1;
    if (o == BQ) return 2'd2;
    if (o == JL) return 2'd3;
    return 2'd0;
  endfunction

  function automatic void build(logic [6:0] o);
    seq.delete();
    seq.push_back(T_DECODE);
    case (o)
      LW: begin
        seq.push_back(T_MEMADR);
        seq.push_back(T_MEMREAD);
        seq.push_back(T_MEMWB);
      end
      SW: begin
        seq.push_back(T_MEMADR);
        seq.push_back(T_MEMWRITE);
      end
      RT: begin seq.push_back(T_EXECR); seq.push_back(T_ALUWB); end
      IT: begin seq.push_back(T_EXECI); seq.push_back(T_ALUWB); end
      JL: begin seq.push_back(T_JAL); seq.push_back(T_ALUWB); end
      BQ: seq.push_back(T_BEQ);
      default: ;
    endcase
  endfunction

  task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s state=%s got=%0h want=%0h t=%0t",
               name, m_state.name(), act, exp, $time);
    end
  endtask

  task automatic step(logic [6:0] nop, logic [2:0] f3, logic f7,
                      logic z, logic rn);
    @(posedge clk);
    #1;
    if (!reset_n) begin
      m_state = T_FETCH;
      seq.delete();
    end else if (seq.size() > 0) begin
      m_state = seq.pop_front();
    end else begin
      m_state = T_FETCH;
    end
    reset_n = rn;
    if (!rn) begin
      m_state = T_FETCH;
      seq.delete();
    end
    if (m_state == T_FETCH) begin
      op = nop;
      build(nop);
    end
    funct3 = f3;
    funct7b5 = f7;
    zero = z;
    #1;
  endtask

  always @(negedge clk) begin
    if (run) begin
      r = row(m_state);
      chk("pcwrite", 8'(pcwrite),
          8'(reset_n & (r.pcu | (r.br & zero))));
      chk("irwrite", 8'(irwrite), 8'(reset_n & r.ir));
      chk("regwrite", 8'(regwrite), 8'(reset_n & r.rw));
      chk("memwrite", 8'(memwrite), 8'(reset_n & r.mw));
      chk("adrsrc", 8'(adrsrc), 8'(r.adr));
      chk("resultsrc", 8'(resultsrc), 8'(r.rs));
      chk("alusrca", 8'(alusrca), 8'(r.a));
      chk("alusrcb", 8'(alusrcb), 8'(r.b));
      chk("immsrc", 8'(immsrc), 8'(imm_exp(op)));
      chk("alucontrol", 8'(alucontrol),
          8'(alu_exp(r.aop, funct3, op[5], funct7b5)));
    end
  end

  initial begin
    logic [6:0] o;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #2;
    run = 1;
    chk("rst_irwrite", 8'(irwrite), 8'd0);
    chk("rst_pcwrite", 8'(pcwrite), 8'd0);
    chk("rst_alusrcb", 8'(alusrcb), 8'd2);
    chk("rst_resultsrc", 8'(resultsrc), 8'd2);

    step(LW, 0, 0, 0, 1);
    chk("lw_fetch_ir", 8'(irwrite), 8'd1);
    chk("lw_fetch_pc", 8'(pcwrite), 8'd1);
    step(LW, 0, 0, 0, 1);
    chk("lw_decode_a", 8'(alusrca), 8'd1);
    chk("lw_decode_rw", 8'(regwrite), 8'd0);
    step(LW, 0, 0, 0, 1);
    chk("lw_memadr_a", 8'(alusrca), 8'd2);
    chk("lw_memadr_b", 8'(alusrcb), 8'd1);
    step(LW, 0, 0, 0, 1);
    chk("lw_memread_adr", 8'(adrsrc), 8'd1);
    chk("lw_memread_rw", 8'(regwrite), 8'd0);
    step(LW, 0, 0, 0, 1);
    chk("lw_memwb_rw", 8'(regwrite), 8'd1);
    chk("lw_memwb_rs", 8'(resultsrc), 8'd1);

    step(RT, 0, 1, 0, 1);
    chk("lw_done_fetch", 8'(irwrite), 8'd1);
    step(RT, 0, 1, 0, 1);
    step(RT, 0, 1, 0, 1);
    chk("sub_alu", 8'(alucontrol), 8'd1);
    funct7b5 = 1'b0;
    #1;
    chk("add_alu", 8'(alucontrol), 8'd0);
    step(RT, 0, 0, 0, 1);
    chk("r_aluwb_rw", 8'(regwrite), 8'd1);

    step(IT, 0, 1, 0, 1);
    step(IT, 0, 1, 0, 1);
    step(IT, 0, 1, 0, 1);
    chk("addi_alu", 8'(alucontrol), 8'd0);
    step(IT, 0, 1, 0, 1);

    step(BQ, 0, 0, 0, 1);
    chk("beq_imm", 8'(immsrc), 8'd2);
    step(BQ, 0, 0, 0, 1);
    step(BQ, 0, 0, 1, 1);
    chk("beq_taken", 8'(pcwrite), 8'd1);
    chk("beq_alu", 8'(alucontrol), 8'd1);
    zero = 1'b0;
    #1;
    chk("beq_not_taken", 8'(pcwrite), 8'd0);

    step(7'b0000000, 0, 0, 0, 1);
    chk("beq_next_fetch", 8'(irwrite), 8'd1);
    step(7'b0000000, 0, 0, 0, 1);
    chk("bad_decode_mw", 8'(memwrite), 8'd0);
    chk("bad_decode_rw", 8'(regwrite), 8'd0);
    step(SW, 0, 0, 0, 1);
    chk("bad_back_fetch", 8'(irwrite), 8'd1);
    chk("sw_imm", 8'(immsrc), 8'd1);
    step(SW, 0, 0, 0, 1);
    step(SW, 0, 0, 0, 1);
    step(SW, 0, 0, 0, 1);
    chk("sw_memwrite", 8'(memwrite), 8'd1);
    reset_n = 1'b0;
    m_state = T_FETCH;
    seq.delete();
    #1;
    chk("async_memwrite", 8'(memwrite), 8'd0);
    chk("async_irwrite", 8'(irwrite), 8'd0);
    chk("async_alusrcb", 8'(alusrcb), 8'd2);
    step(SW, 0, 0, 0, 0);
    chk("held_irwrite", 8'(irwrite), 8'd0);
    chk("held_pcwrite", 8'(pcwrite), 8'd0);
    step(JL, 0, 0, 0, 1);
    chk("release_irwrite", 8'(irwrite), 8'd1);
    chk("release_pcwrite", 8'(pcwrite), 8'd1);

    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 7))
        0: o = LW;
        1: o = SW;
        2: o = RT;
        3: o = IT;
        4: o = JL;
        5: o = BQ;
        default: o = 7'($urandom);
      endcase
      step(o, 3'($urandom), 1'($urandom), 1'($urandom),
           1'($urandom_range(0, 49) != 0));
    end

    @(posedge clk);
    run = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
